// File: rtl/m_win_gen_3_pkg.sv
// Layer-3 window generator constants and FSM state type.
package m_win_gen_3_pkg;

  localparam int unsigned MAP_W   = 22;
  localparam int unsigned MAP_H   = 22;
  localparam int unsigned K       = 5;
  localparam int unsigned DW      = 16;
  localparam int unsigned AW      = 9;
  localparam int unsigned OUT_W   = MAP_W - K + 1;
  localparam int unsigned N_BEATS = OUT_W * OUT_W * K * K;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage : m_win_gen_3_pkg

// File: rtl/m_map_ram_3.sv
// Simple dual-port map buffer: synchronous write, registered read, no reset.
module m_map_ram_3 #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 9
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Write port plus registered read; the read register holds when re_i is low.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule : m_map_ram_3

// File: rtl/m_win_gen_3.sv
// Captures one pooled map, then streams it as KxK stride-1 windows in
// kernel-element order; rearms for the next map after the last window.
module m_win_gen_3
  import m_win_gen_3_pkg::*;
#(
  parameter int unsigned MAP_W = m_win_gen_3_pkg::MAP_W,
  parameter int unsigned MAP_H = m_win_gen_3_pkg::MAP_H,
  parameter int unsigned K     = m_win_gen_3_pkg::K,
  parameter int unsigned DW    = m_win_gen_3_pkg::DW,
  parameter int unsigned AW    = m_win_gen_3_pkg::AW
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] din,
  input  logic                 wr,
  input  logic                 rd_en,
  output logic signed [DW-1:0] dout,
  output logic                 dout_valid,
  output logic                 win_last,
  output logic                 map_last,
  output logic                 full,
  output logic                 done,
  output logic                 ovf
);

  localparam logic [4:0]    OX_LAST  = 5'(MAP_W - K);
  localparam logic [4:0]    OY_LAST  = 5'(MAP_H - K);
  localparam logic [2:0]    K_LAST   = 3'(K - 1);
  localparam logic [AW-1:0] ROW_STEP = AW'(MAP_W);
  localparam logic [AW-1:0] WR_LAST  = AW'(MAP_W * MAP_H - 1);

  state_e        state_q;
  logic [AW-1:0] wr_addr_q;
  logic [AW-1:0] row_base_q;
  logic [AW-1:0] win_base_q;
  logic [4:0]    ox_q, oy_q;
  logic [2:0]    kx_q, ky_q;
  logic          dout_valid_q, win_last_q, map_last_q, done_q;
  logic          full_q, ovf_q, dout_ok_q;

  logic          issue_d;
  logic          we_d;
  logic          k_end_d;
  logic          map_end_d;
  logic [AW-1:0] rd_addr_d;
  logic [DW-1:0] ram_rdata;

  // Read address and issue/write qualifiers from the current counter state.
  always_comb begin
    issue_d   = (state_q == STREAM) && rd_en;
    we_d      = (state_q == FILL) && wr;
    k_end_d   = (kx_q == K_LAST) && (ky_q == K_LAST);
    map_end_d = k_end_d && (ox_q == OX_LAST) && (oy_q == OY_LAST);
    rd_addr_d = row_base_q + AW'(ox_q) + AW'(kx_q);
  end

  m_map_ram_3 #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk_i   (clk_in),
    .we_i    (we_d),
    .waddr_i (wr_addr_q),
    .wdata_i (din),
    .re_i    (issue_d),
    .raddr_i (rd_addr_d),
    .rdata_o (ram_rdata)
  );

  // FSM, fill pointer, window counters and registered beat flags.
  // row_base steps by MAP_W per ky and reloads from win_base at each new
  // window, so the read address needs only adds.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      wr_addr_q    <= '0;
      row_base_q   <= '0;
      win_base_q   <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
      kx_q         <= '0;
      ky_q         <= '0;
      dout_valid_q <= 1'b0;
      win_last_q   <= 1'b0;
      map_last_q   <= 1'b0;
      done_q       <= 1'b0;
      full_q       <= 1'b0;
      ovf_q        <= 1'b0;
      dout_ok_q    <= 1'b0;
    end else begin
      dout_valid_q <= issue_d;
      win_last_q   <= issue_d && k_end_d;
      map_last_q   <= issue_d && map_end_d;
      done_q       <= issue_d && map_end_d;
      if (issue_d) dout_ok_q <= 1'b1;

      case (state_q)
        FILL: begin
          if (wr) begin
            if (wr_addr_q == WR_LAST) begin
              wr_addr_q <= '0;
              state_q   <= STREAM;
              full_q    <= 1'b1;
            end else begin
              wr_addr_q <= wr_addr_q + 1'b1;
            end
          end
        end
        STREAM: begin
          if (wr) ovf_q <= 1'b1;
          if (rd_en) begin
            if (kx_q != K_LAST) begin
              kx_q <= kx_q + 3'd1;
            end else begin
              kx_q <= '0;
              if (ky_q != K_LAST) begin
                ky_q       <= ky_q + 3'd1;
                row_base_q <= row_base_q + ROW_STEP;
              end else begin
                ky_q <= '0;
                if (ox_q != OX_LAST) begin
                  ox_q       <= ox_q + 5'd1;
                  row_base_q <= win_base_q;
                end else begin
                  ox_q <= '0;
                  if (oy_q != OY_LAST) begin
                    oy_q       <= oy_q + 5'd1;
                    win_base_q <= win_base_q + ROW_STEP;
                    row_base_q <= win_base_q + ROW_STEP;
                  end else begin
                    oy_q       <= '0;
                    win_base_q <= '0;
                    row_base_q <= '0;
                    state_q    <= FILL;
                    full_q     <= 1'b0;
                  end
                end
              end
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  // The RAM read register has no reset, so dout is forced to 0 until the
  // first read after reset; afterwards it holds the last element read.
  assign dout       = dout_ok_q ? ram_rdata : '0;
  assign dout_valid = dout_valid_q;
  assign win_last   = win_last_q;
  assign map_last   = map_last_q;
  assign done       = done_q;
  assign full       = full_q;
  assign ovf        = ovf_q;

endmodule : m_win_gen_3

// File: tb/tb_m_win_gen_3.sv
// Directed bench for m_win_gen_3 with a window-order scoreboard.
module tb_m_win_gen_3;
  import m_win_gen_3_pkg::*;

  localparam int unsigned NPIX = MAP_W * MAP_H;

  typedef struct packed {
    logic [15:0] d;
    logic        wl;
    logic        ml;
  } exp_t;

  logic               clk_in = 1'b0;
  logic               rst_n;
  logic signed [15:0] din;
  logic               wr;
  logic               rd_en;
  logic signed [15:0] dout;
  logic               dout_valid, win_last, map_last, full, done, ovf;

  int   checks   = 0;
  int   failures = 0;
  int   beats    = 0;
  int   wl_cnt   = 0;
  int   ml_cnt   = 0;
  logic [15:0] last_exp = '0;
  logic [15:0] img [0:NPIX-1];
  exp_t exp_q [$];
  exp_t mon_e;

  always #5 clk_in = ~clk_in;

  m_win_gen_3 #(
    .MAP_W(MAP_W),
    .MAP_H(MAP_H),
    .K    (K),
    .DW   (DW),
    .AW   (AW)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .din       (din),
    .wr        (wr),
    .rd_en     (rd_en),
    .dout      (dout),
    .dout_valid(dout_valid),
    .win_last  (win_last),
    .map_last  (map_last),
    .full      (full),
    .done      (done),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int unsigned a, input int mode);
    case (mode)
      1:       return 16'(a * 37) ^ 16'h8000;
      2:       return 16'hFFFF - 16'(a);
      default: return 16'(a);
    endcase
  endfunction

  // Expected beats in window order, derived from the written image.
  task automatic push_expected();
    exp_t e;
    beats  = 0;
    wl_cnt = 0;
    ml_cnt = 0;
    for (int oy = 0; oy < OUT_W; oy++)
      for (int ox = 0; ox < OUT_W; ox++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            e.d  = img[(oy + ky) * MAP_W + ox + kx];
            e.wl = (kx == K - 1) && (ky == K - 1);
            e.ml = e.wl && (ox == OUT_W - 1) && (oy == OUT_W - 1);
            exp_q.push_back(e);
          end
  endtask

  // Writes a full map with one wr every `gap` cycles while rd_en is held high.
  task automatic fill(input int mode, input int gap);
    rd_en = 1'b1;
    @(posedge clk_in); #1;
    for (int unsigned a = 0; a < NPIX; a++) begin
      wr  = 1'b1;
      din = pat(a, mode);
      img[a] = pat(a, mode);
      if (a == NPIX - 1) push_expected();
      @(posedge clk_in); #1;
      wr = 1'b0;
      if (a == NPIX - 2) chk("full_before_last_wr", {31'd0, full}, 32'd0);
      if (a < NPIX - 1 && gap > 1)
        repeat (gap - 1) begin @(posedge clk_in); #1; end
    end
    chk("full_rise", {31'd0, full}, 32'd1);
    chk("valid_first_stream_cycle", {31'd0, dout_valid}, 32'd0);
    @(posedge clk_in); #1;
    chk("first_beat_valid", {31'd0, dout_valid}, 32'd1);
    chk("first_beat_data", {16'd0, dout}, {16'd0, img[0]});
  endtask

  task automatic wait_beats(input int n);
    int c = 0;
    while (beats < n && c < 20000) begin @(posedge clk_in); c++; end
    chk("wait_beats_timeout", {31'd0, (c >= 20000)}, 32'd0);
  endtask

  task automatic drain_and_count();
    int c = 0;
    while (exp_q.size() != 0 && c < 20000) begin @(posedge clk_in); c++; end
    chk("drain_timeout", exp_q.size(), 0);
    #1;
    chk("full_after_map", {31'd0, full}, 32'd0);
    chk("valid_after_map", {31'd0, dout_valid}, 32'd0);
    chk("beat_count", beats, N_BEATS);
    chk("win_last_count", wl_cnt, OUT_W * OUT_W);
    chk("map_last_count", ml_cnt, 1);
  endtask

  // Scoreboard: every valid beat pops one expected element.
  always @(negedge clk_in) begin
    if (dout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("dout", {16'd0, dout}, {16'd0, mon_e.d});
        chk("win_last", {31'd0, win_last}, {31'd0, mon_e.wl});
        chk("map_last", {31'd0, map_last}, {31'd0, mon_e.ml});
        chk("done", {31'd0, done}, {31'd0, mon_e.ml});
        last_exp = mon_e.d;
        beats++;
        if (win_last) wl_cnt++;
        if (map_last) ml_cnt++;
      end
    end else if (rst_n === 1'b1) begin
      chk("idle_flags", {29'd0, win_last, map_last, done}, 32'd0);
    end
  end

  initial begin
    rst_n = 1'b0;
    wr    = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    #1;
    chk("reset_outputs", {16'd0, dout}, 32'd0);
    chk("reset_flags", {26'd0, dout_valid, win_last, map_last, full, done, ovf}, 32'd0);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;

    // Map A: din = address, continuous rd_en, a 2-cycle stall in window 2.
    fill(0, 1);
    wait_beats(27);
    #1 rd_en = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    chk("stall1_valid", {31'd0, dout_valid}, 32'd0);
    chk("stall1_hold", {16'd0, dout}, {16'd0, last_exp});
    @(posedge clk_in);
    @(negedge clk_in);
    chk("stall2_valid", {31'd0, dout_valid}, 32'd0);
    chk("stall2_hold", {16'd0, dout}, {16'd0, last_exp});
    rd_en = 1'b1;
    @(negedge clk_in);
    chk("stall_resume_valid", {31'd0, dout_valid}, 32'd1);
    drain_and_count();
    chk("ovf_clean", {31'd0, ovf}, 32'd0);

    // Map B: sparse fill, then a stray write during STREAM.
    fill(1, 16);
    wait_beats(500);
    @(posedge clk_in); #1;
    wr  = 1'b1;
    din = 16'sh7FFF;
    @(posedge clk_in); #1;
    wr = 1'b0;
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    drain_and_count();
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);

    // Map C: reset in the middle of streaming.
    fill(2, 1);
    wait_beats(1000);
    @(posedge clk_in); #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_dout", {16'd0, dout}, 32'd0);
    chk("async_reset_flags", {26'd0, dout_valid, win_last, map_last, full, done, ovf}, 32'd0);
    exp_q.delete();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
    chk("post_reset_full", {31'd0, full}, 32'd0);
    chk("post_reset_ovf", {31'd0, ovf}, 32'd0);

    // Map D: fresh map after reset.
    fill(0, 1);
    drain_and_count();
    chk("ovf_after_reset_map", {31'd0, ovf}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_m_win_gen_3
